bcd2bin_seq: RTL and testbench
==============================

# bcd2bin_seq

Sequential BCD-to-binary converter for the digital clock's time-set path. It converts user-entered BCD digits (hours, minutes or seconds fields) back into the binary counter values held by the timekeeping core. It runs the reverse double-dabble algorithm (shift right, subtract 3 from any digit ≥ 8), one bit per clock. A start/done handshake frames each conversion, and the block flags invalid BCD digits and out-of-range field values.

## Interface
- DIGITS, 2: number of BCD digits on `bcd_in`.
- BIN_W, 7: binary result width; must satisfy 2^BIN_W ≥ 10^DIGITS.
- MAX_VAL, 59: largest legal field value (59 for minutes/seconds, 23 for hours).
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, most significant digit in the MSBs.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; `number` and `err` are valid from this cycle.
- number  output  BIN_W  binary result; held until the next `done`.
- err  output  1  invalid digit or range violation; held until the next `done`.

## Operation
- States: IDLE, CONV, FINISH.
- IDLE with start=1:
  - Load shift register S ← bcd_in and B ← 0. Clear the iteration counter.
  - If any digit > 9: set internal bad flag and go to FINISH.
  - Otherwise go to CONV.
- CONV, each cycle:
  - {S,B} ← {S,B} >> 1.
  - Then, for every 4-bit digit of the shifted S: if digit ≥ 8, subtract 3.
  - Increment the counter. After BIN_W iterations go to FINISH.
- FINISH:
  - If bad: number ← 0, err ← 1.
  - Otherwise: number ← B, err ← range flag (see Configuration).
  - done ← 1 for exactly one cycle, then return to IDLE.
- busy = (state ≠ IDLE), registered.
- start outside IDLE is ignored and is not queued.
- start is level-sampled: if held high, a new conversion begins on the first IDLE cycle.
- Arithmetic:
  - Digit corrections are 4-bit and unsigned.
  - The range compare is an unsigned BIN_W-bit compare against MAX_VAL.
  - bcd_in only needs to be stable in the cycle start is accepted.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, number=0, err=0, S=0, B=0, counter=0.
- Edge numbering: E0 is the edge that accepts start.
- Valid digits:
  - CONV iterations occur at E1..E_BIN_W.
  - done=1 after E(BIN_W+1), giving a latency of BIN_W+1 edges (8 for defaults).
- Invalid digit: done=1 after E1, giving a latency of 1 edge.
- busy rises after E0 and falls on the same edge that raises done.
- The earliest next start is accepted on the edge after done. Back-to-back period is BIN_W+2 cycles (9 for defaults).
- Reset mid-conversion aborts immediately. No done is produced, and all outputs go to their reset values.

## Configuration
- `BCD2BIN_RANGE_CHECK_EN` defined:
  - In FINISH, err=1 when number > MAX_VAL.
  - number still carries the converted value.
- Undefined:
  - MAX_VAL is ignored and no comparator is built.
  - err reflects only invalid BCD digits.

## Test plan
- Reset released, bcd_in=8'h21, pulse start → busy after E0; done after E8 with number=21, err=0; busy=0 in the done cycle.
- Sequential conversions of 8'h00, 8'h16, 8'h59 → number=0, 16, 59; err=0 for each; exactly one done pulse per request.
- bcd_in=8'h60, start → number=60, err=1 with `BCD2BIN_RANGE_CHECK_EN`; err=0 without it.
- bcd_in=8'h3A, start → done after E1, number=0, err=1; a following 8'h23 request → 23, err=0.
- start held high continuously with bcd_in=8'h45 → done every 9 cycles, number=45; toggling bcd_in while busy does not change the in-flight result.
- Start 8'h21, assert rst_n=0 after E3 → outputs immediately 0 and no done. Release, start 8'h16 → number=16 after E8.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// bcd2bin_seq
// Sequential BCD-to-binary converter for the clock's time-set path.
// Runs the reverse double-dabble algorithm one bit per clock. Each iteration
// shifts {S,B} right by one bit, then subtracts 3 from every BCD digit of S
// that is 8 or more. A start/done handshake frames each conversion. Digits
// above 9 are flagged immediately and skip the shift phase.
//
// Optional feature macro: BCD2BIN_RANGE_CHECK_EN
//   When defined, err is also raised when the converted value exceeds MAX_VAL.
//   When undefined, no comparator is built and MAX_VAL is only sanity-checked.
// -----------------------------------------------------------------------------
module bcd2bin_seq #(
    parameter int DIGITS  = 2,
    parameter int BIN_W   = 7,
    parameter int MAX_VAL = 59
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      number,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    // Parameter sanity: the binary field must hold every DIGITS-digit value,
    // and the legal maximum must fit in that field.
    if ((1 << BIN_W) < (10 ** DIGITS)) begin : g_bin_w_check
        $error("bcd2bin_seq: BIN_W too small for DIGITS");
    end
    if ((MAX_VAL < 0) || (MAX_VAL >= (1 << BIN_W))) begin : g_max_val_check
        $error("bcd2bin_seq: MAX_VAL does not fit in BIN_W bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [BCD_W-1:0]   r_s;
    logic [BIN_W-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bad;
    logic               r_busy;
    logic               r_done;
    logic [BIN_W-1:0]   r_number;
    logic               r_err;

    logic [BCD_W-1:0]   w_shift_s;
    logic [BIN_W-1:0]   w_shift_b;
    logic [BCD_W-1:0]   w_next_s;
    logic               w_in_bad;
    logic               w_range_err;

    // True when any 4-bit digit of the packed BCD word is above 9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Reverse double-dabble correction: every digit >= 8 loses 3 (4-bit, unsigned).
    function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd8) begin
                r[4*d +: 4] = v[4*d +: 4] - 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    // The LSB of S falls into the MSB of B; corrections apply to the shifted S.
    assign w_shift_s = {1'b0, r_s[BCD_W-1:1]};
    assign w_shift_b = {r_s[0], r_b[BIN_W-1:1]};
    assign w_next_s  = correct_digits(w_shift_s);
    assign w_in_bad  = has_bad_digit(bcd_in);

`ifdef BCD2BIN_RANGE_CHECK_EN
    localparam logic [BIN_W-1:0] MAX_VAL_W = BIN_W'(MAX_VAL);
    assign w_range_err = (r_b > MAX_VAL_W);
`else
    assign w_range_err = 1'b0;
`endif

    // Conversion FSM with datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_s      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_number <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_s    <= bcd_in;
                        r_b    <= '0;
                        r_cnt  <= '0;
                        r_bad  <= w_in_bad;
                        r_busy <= 1'b1;
                        if (w_in_bad) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_CONV;
                        end
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b1;
                    r_s    <= w_next_s;
                    r_b    <= w_shift_b;
                    r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_CONV;
                    end
                end
                ST_FINISH: begin
                    if (r_bad) begin
                        r_number <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_number <= r_b;
                        r_err    <= w_range_err;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign number = r_number;
    assign err    = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin_seq
// Directed bench for bcd2bin_seq with hand-computed expected values.
// Honours BCD2BIN_RANGE_CHECK_EN for the out-of-range vector.
// -----------------------------------------------------------------------------
module tb_bcd2bin_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy;
    logic       done;
    logic [6:0] number;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bcd2bin_seq #(.DIGITS(2), .BIN_W(7), .MAX_VAL(59)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .number (number),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to measure done-to-done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge and measure latency in edges after E0.
    task automatic convert(input string tag, input logic [7:0] bcd,
                           input int exp_num, input int exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);           // E0
        #1;
        start  = 1'b0;
        bcd_in = 8'hFF;           // only needs to be stable on E0
        check({tag, "_busy_e0"}, int'(busy), 1);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_num"},  int'(number), exp_num);
        check({tag, "_err"},  int'(err), exp_err);
        check({tag, "_busy_done"}, int'(busy), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_hold_num"},   int'(number), exp_num);
    endtask

    initial begin
        int t_done [3];
        int got;
        start  = 1'b0;
        bcd_in = 8'h00;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_num",  int'(number), 0);
        check("rst_err",  int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic conversion and sequential requests.
        convert("c21", 8'h21, 21, 0, 8);
        convert("c00", 8'h00, 0,  0, 8);
        convert("c16", 8'h16, 16, 0, 8);
        convert("c59", 8'h59, 59, 0, 8);
        convert("c99", 8'h99, 99,
`ifdef BCD2BIN_RANGE_CHECK_EN
                1,
`else
                0,
`endif
                8);

        // Out-of-range field value.
`ifdef BCD2BIN_RANGE_CHECK_EN
        convert("c60", 8'h60, 60, 1, 8);
`else
        convert("c60", 8'h60, 60, 0, 8);
`endif

        // Invalid digit, then a clean request clears err.
        convert("c3A", 8'h3A, 0, 1, 1);
        convert("cA0", 8'hA0, 0, 1, 1);
        convert("c23", 8'h23, 23, 0, 8);

        // start held high: back-to-back every 9 cycles; bcd_in toggled while busy.
        @(negedge clk);
        bcd_in = 8'h45;
        start  = 1'b1;
        @(posedge clk);
        #1;
        bcd_in = 8'h99;
        for (int k = 0; k < 3; k++) begin
            got = 0;
            for (int n = 0; n < 20; n++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    got = 1;
                    break;
                end
            end
            check("held_done_seen", got, 1);
            t_done[k] = cyc;
            check("held_num", int'(number), 45);
            check("held_err", int'(err), 0);
            if (k == 0) begin
                bcd_in = 8'h45;
            end else if (k == 2) begin
                start = 1'b0;
            end
        end
        check("held_period_1", t_done[1] - t_done[0], 9);
        check("held_period_2", t_done[2] - t_done[1], 9);
        repeat (3) @(posedge clk);
        #1;
        check("held_stop_busy", int'(busy), 0);

        // Reset mid-conversion aborts with no done.
        @(negedge clk);
        bcd_in = 8'h21;
        start  = 1'b1;
        @(posedge clk);           // E0
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk); // E1..E3
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_num",  int'(number), 0);
        check("abort_err",  int'(err), 0);
        got = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (done) got = 1;
        end
        check("abort_no_done", got, 0);
        @(negedge clk);
        rst_n = 1'b1;
        convert("c16_after_rst", 8'h16, 16, 0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
